// File: rtl/merger_lane_buffer.sv
// merger_lane_buffer
//   Per-lane input staging for the radix-RADIX coordinate merger. Each lane
//   buffers its input stream in a small FIFO and presents the head (or an
//   all-ones sentinel when empty) on coord_out. The merger pops a lane by
//   asserting that lane's fetch_next bit.
//
// Optional feature macro: MERGER_LANE_BUF_CHECK_EN
//   defined   -> sticky underflow detection on fetch_next to an empty, not-DONE lane
//   undefined -> underflow tied to 0
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   in_coord    lane i push data at [i*COORD_BITS +: COORD_BITS]
//   in_valid    lane i push request
//   in_last     marks the final coordinate of lane i's stream
//   in_ready    lane i can accept a push this cycle
//   coord_out   lane heads or all-ones sentinels (merger coord_in)
//   fetch_next  merger pop request per lane
//   lane_empty  lane i FIFO holds no entries
//   all_done    every lane has reached DONE (registered)
//   underflow   sticky error flag (only with MERGER_LANE_BUF_CHECK_EN)

module merger_lane_buffer #(
  parameter int unsigned COORD_BITS = 8,
  parameter int unsigned RADIX      = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [RADIX*COORD_BITS-1:0] in_coord,
  input  logic [RADIX-1:0]            in_valid,
  input  logic [RADIX-1:0]            in_last,
  output logic [RADIX-1:0]            in_ready,
  output logic [RADIX*COORD_BITS-1:0] coord_out,
  input  logic [RADIX-1:0]            fetch_next,
  output logic [RADIX-1:0]            lane_empty,
  output logic                        all_done,
  output logic                        underflow
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } lane_state_e;

  logic [RADIX-1:0] lane_done;
`ifdef MERGER_LANE_BUF_CHECK_EN
  logic [RADIX-1:0] lane_uf;
`endif

  for (genvar g = 0; g < RADIX; g++) begin : g_lane
    logic [COORD_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]   wptr;
    logic [PTR_BITS-1:0]   rptr;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_nxt;
    lane_state_e           state;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_BITS'(DEPTH));

    // Ready depends only on registered state, never on fetch_next.
    assign in_ready[g] = !full && (state == FILL);

    assign push = in_valid[g] && in_ready[g];
    assign pop  = fetch_next[g] && !empty;

    // Occupancy after this edge; simultaneous push and pop cancel.
    always_comb begin
      count_nxt = count;
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_BITS'(1);
        2'b01:   count_nxt = count - CNT_BITS'(1);
        default: count_nxt = count;
      endcase
    end

    // Pointers, occupancy and lane FSM.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        state <= FILL;
      end else begin
        if (push) wptr <= wptr + PTR_BITS'(1);
        if (pop)  rptr <= rptr + PTR_BITS'(1);
        count <= count_nxt;
        case (state)
          FILL:    if (push && in_last[g]) state <= DRAIN;
          DRAIN:   if (count_nxt == '0)    state <= DONE;
          DONE:    state <= DONE;
          default: state <= FILL;
        endcase
      end
    end

    // Storage needs no reset: contents are masked whenever the lane is empty.
    always_ff @(posedge clock) begin
      if (push) mem[wptr] <= in_coord[g*COORD_BITS +: COORD_BITS];
    end

    assign coord_out[g*COORD_BITS +: COORD_BITS] = empty ? '1 : mem[rptr];
    assign lane_empty[g] = empty;
    assign lane_done[g]  = (state == DONE);

`ifdef MERGER_LANE_BUF_CHECK_EN
    assign lane_uf[g] = fetch_next[g] && empty && (state != DONE);
`endif
  end

  // all_done trails the last lane's DONE entry by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) all_done <= 1'b0;
    else        all_done <= &lane_done;
  end

`ifdef MERGER_LANE_BUF_CHECK_EN
  // Sticky until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) underflow <= 1'b0;
    else        underflow <= underflow | (|lane_uf);
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_merger_lane_buffer.sv
// tb_merger_lane_buffer
//   Directed bench for merger_lane_buffer (COORD_BITS=8, RADIX=4, DEPTH=4).
//   A queue-per-lane reference model predicts heads, ready/empty flags,
//   all_done and underflow; popped data is compared against the model queue.

module tb_merger_lane_buffer;

  logic        clock;
  logic        reset;
  logic [31:0] in_coord;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [31:0] coord_out;
  logic [3:0]  fetch_next;
  logic [3:0]  lane_empty;
  logic        all_done;
  logic        underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] mq [4][$];
  int         mst [4];   // 0 FILL, 1 DRAIN, 2 DONE
  logic       mdone;
  logic       munder;

  merger_lane_buffer #(
    .COORD_BITS(8),
    .RADIX     (4),
    .DEPTH     (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_coord  (in_coord),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .coord_out (coord_out),
    .fetch_next(fetch_next),
    .lane_empty(lane_empty),
    .all_done  (all_done),
    .underflow (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mst[i] = 0;
    end
    mdone  = 1'b0;
    munder = 1'b0;
  endtask

  // Outputs that must hold while reset is low, independent of the clock.
  task automatic chk_reset_values();
    chk("rst_coord_out",  coord_out, 32'hFFFF_FFFF);
    chk("rst_in_ready",   32'(in_ready), 32'hF);
    chk("rst_lane_empty", 32'(lane_empty), 32'hF);
    chk("rst_all_done",   32'(all_done), 32'h0);
    chk("rst_underflow",  32'(underflow), 32'h0);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, pop the
  // scoreboard for every lane the merger drains, then advance the model.
  task automatic cycle(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic [3:0] f);
    logic [31:0] ec;
    logic [3:0]  er;
    logic [3:0]  ee;
    logic [7:0]  ev;
    logic        nd;
    in_valid   = v;
    in_last    = l;
    in_coord   = d;
    fetch_next = f;
    #1;
    for (int i = 0; i < 4; i++) begin
      ee[i] = (mq[i].size() == 0);
      er[i] = (mq[i].size() < 4) && (mst[i] == 0);
      ec[i*8 +: 8] = ee[i] ? 8'hFF : mq[i][0];
    end
    chk("coord_out",  coord_out, ec);
    chk("in_ready",   32'(in_ready), 32'(er));
    chk("lane_empty", 32'(lane_empty), 32'(ee));
    chk("all_done",   32'(all_done), 32'(mdone));
    chk("underflow",  32'(underflow), 32'(munder));
    nd = 1'b1;
    for (int i = 0; i < 4; i++) if (mst[i] != 2) nd = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MERGER_LANE_BUF_CHECK_EN
      if (f[i] && ee[i] && mst[i] != 2) munder = 1'b1;
`endif
      if (f[i] && !ee[i]) begin
        ev = mq[i].pop_front();
        chk($sformatf("pop_data_lane%0d", i), 32'(coord_out[i*8 +: 8]), 32'(ev));
      end
      if (v[i] && er[i]) mq[i].push_back(d[i*8 +: 8]);
      if (v[i] && er[i] && l[i]) mst[i] = 1;
      else if (mst[i] == 1 && mq[i].size() == 0) mst[i] = 2;
    end
    @(posedge clock);
    #1;
    mdone = nd;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic mid_reset();
    in_valid   = '0;
    in_last    = '0;
    in_coord   = '0;
    fetch_next = '0;
    reset      = 1'b0;
    #1;
    model_reset();
    chk_reset_values();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = '0;
    in_last    = '0;
    in_coord   = '0;
    fetch_next = '0;
    model_reset();

    // Reset asserted before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Fill lane 0 to full; a fifth push must be refused.
    cycle(4'b0001, 4'b0000, 32'h10, 4'b0000);
    cycle(4'b0001, 4'b0000, 32'h11, 4'b0000);
    cycle(4'b0001, 4'b0000, 32'h12, 4'b0000);
    cycle(4'b0001, 4'b0000, 32'h13, 4'b0000);
    chk("full_ready0", 32'(in_ready[0]), 32'h0);
    chk("full_head0",  32'(coord_out[7:0]), 32'h10);
    cycle(4'b0001, 4'b0000, 32'h14, 4'b0000);

    // Push attempt and pop together on the full lane: pop frees a slot next cycle.
    cycle(4'b0001, 4'b0000, 32'h15, 4'b0001);
    chk("freed_ready0", 32'(in_ready[0]), 32'h1);
    chk("next_head0",   32'(coord_out[7:0]), 32'h11);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0001);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0001);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0001);

    // Streaming through lane 2 across several pointer wraps.
    for (int k = 0; k < 10; k++)
      cycle(4'b0100, 4'b0000, 32'(k) << 16, (k > 0) ? 4'b0100 : 4'b0000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0100);
    for (int k = 0; k < 4; k++)
      cycle(4'b0100, 4'b0000, 32'(8'hA0 + k) << 16, 4'b0000);
    for (int k = 0; k < 4; k++)
      cycle(4'b0000, 4'b0000, 32'h0, 4'b0100);

    // Pop request to an empty lane still in FILL.
    cycle(4'b0000, 4'b0000, 32'h0, 4'b1000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);

    // End of stream on lane 1; pushes in DRAIN/DONE are ignored.
    cycle(4'b0010, 4'b0010, 32'h0000_0500, 4'b0000);
    chk("drain_ready1", 32'(in_ready[1]), 32'h0);
    cycle(4'b0010, 4'b0000, 32'h0000_0600, 4'b0010);
    chk("done_coord1", 32'(coord_out[15:8]), 32'hFF);
    cycle(4'b0010, 4'b0010, 32'h0000_0700, 4'b0010);

    // Remaining lanes finish together; all_done one cycle after DONE.
    cycle(4'b1101, 4'b1101, 32'h4030_0020, 4'b0000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b1101);
    chk("all_done_lag", 32'(all_done), 32'h0);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);
    chk("all_done_set", 32'(all_done), 32'h1);
    cycle(4'b1111, 4'b1111, 32'h5555_5555, 4'b1111);

    // Reset mid-stream discards buffered entries.
    mid_reset();
    cycle(4'b1001, 4'b0000, 32'h8800_0077, 4'b0000);
    cycle(4'b1001, 4'b0000, 32'h8900_0078, 4'b0000);
    in_valid = 4'b1001;
    #2;
    mid_reset();
    cycle(4'b0001, 4'b0000, 32'h0000_0099, 4'b0000);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0001);
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
